// File: rtl/gpu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | gpu_pkg : shared constants for the layer compositor                  |
// | Rev 1.0 : initial release                                            |
// +----------------------------------------------------------------------+
package gpu_pkg;

    localparam int COLOR_WIDTH = 12;

    // Word offsets of the control block, relative to the end of layer space
    localparam logic [1:0] CTRL_LAYER_EN = 2'd0;
    localparam logic [1:0] CTRL_KEY      = 2'd1;
    localparam logic [1:0] CTRL_BG       = 2'd2;
    localparam logic [1:0] CTRL_COMMIT   = 2'd3;
    localparam logic [31:0] CTRL_WORDS   = 32'd4;

    localparam logic [COLOR_WIDTH-1:0] KEY_COLOR_RESET = 12'hFFF;
    localparam logic [COLOR_WIDTH-1:0] BG_COLOR_RESET  = 12'h000;

endpackage
`default_nettype wire

// File: rtl/gpu_layer_mux.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | gpu_layer_mux : picks the lowest enabled, non-keyed layer colour     |
// | Rev 1.0 : initial release                                            |
// +----------------------------------------------------------------------+
module gpu_layer_mux #(
    parameter int LAYER_COUNT = 5,
    parameter int COLOR_WIDTH = 12
) (
    input  logic [LAYER_COUNT*COLOR_WIDTH-1:0] layer_pixel,
    input  logic [LAYER_COUNT-1:0]             layer_en,
    input  logic [COLOR_WIDTH-1:0]             key_color,
    input  logic [COLOR_WIDTH-1:0]             bg_color,
    output logic [COLOR_WIDTH-1:0]             color
);
    import gpu_pkg::*;

    // Walk from the top layer down so the lowest index wins
    always_comb begin
        color = bg_color;
        for (int i = LAYER_COUNT - 1; i >= 0; i--) begin
            if (layer_en[i] && (layer_pixel[i*COLOR_WIDTH +: COLOR_WIDTH] != key_color)) begin
                color = layer_pixel[i*COLOR_WIDTH +: COLOR_WIDTH];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/gpu_compositor.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | gpu_compositor : layer write decode, double-buffered control and     |
// |                  two-stage colour-key compositing pipeline           |
// | Rev 1.0 : initial release                                            |
// +----------------------------------------------------------------------+
module gpu_compositor #(
    parameter int LAYER_COUNT      = 5,
    parameter int LAYER_ADDR_SIZE  = 4216,
    parameter int ADDR_WIDTH       = 24,
    parameter int DATA_WIDTH       = 32,
    parameter int COLOR_WIDTH      = gpu_pkg::COLOR_WIDTH,
    parameter int LAYER_ADDR_WIDTH = 16
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [ADDR_WIDTH-1:0]              waddr,
    input  logic [DATA_WIDTH-1:0]              wdata,
    input  logic                               wen,
    output logic [LAYER_ADDR_WIDTH-1:0]        layer_waddr,
    output logic [15:0]                        layer_wdata,
    output logic [LAYER_COUNT-1:0]             layer_wen,
    input  logic                               pixel_en,
    input  logic                               frame_start,
    input  logic                               visible,
    input  logic [LAYER_COUNT*COLOR_WIDTH-1:0] layer_pixel,
    output logic [COLOR_WIDTH/3-1:0]           red,
    output logic [COLOR_WIDTH/3-1:0]           green,
    output logic [COLOR_WIDTH/3-1:0]           blue,
    output logic                               commit_pending
);
    import gpu_pkg::*;

    localparam logic [31:0] LAS       = 32'(LAYER_ADDR_SIZE);
    localparam logic [31:0] CTRL_BASE = 32'(LAYER_COUNT * LAYER_ADDR_SIZE);
    localparam int          THIRD     = COLOR_WIDTH / 3;

    logic [31:0] word_idx;
    logic [31:0] layer_idx;
    logic [31:0] ctrl_off;
    logic        is_layer;
    logic        ctrl_wr;
    logic        apply;
    logic        unused_bits;

    logic [LAYER_COUNT-1:0] st_en, act_en;
    logic [COLOR_WIDTH-1:0] st_key, act_key, st_bg, act_bg;

    logic [LAYER_COUNT*COLOR_WIDTH-1:0] pix_s1;
    logic                               vis_s1;
    logic [COLOR_WIDTH-1:0]             mux_color;
    logic [COLOR_WIDTH-1:0]             color_out;

    assign word_idx    = 32'(waddr[ADDR_WIDTH-1:2]);
    assign layer_idx   = word_idx / LAS;
    assign is_layer    = word_idx < CTRL_BASE;
    assign ctrl_off    = word_idx - CTRL_BASE;
    assign ctrl_wr     = wen && !is_layer && (ctrl_off < CTRL_WORDS);
    assign apply       = frame_start && pixel_en && commit_pending;
    assign unused_bits = ^{waddr[1:0], wdata[DATA_WIDTH-1:16]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            layer_wen   <= '0;
            layer_waddr <= '0;
            layer_wdata <= '0;
        end else begin
            layer_wen <= '0;
            if (wen && is_layer) begin
                for (int i = 0; i < LAYER_COUNT; i++) begin
                    layer_wen[i] <= (layer_idx == 32'(i));
                end
                // Remainder via multiply-back keeps a single divider
                layer_waddr <= LAYER_ADDR_WIDTH'(word_idx - layer_idx * LAS);
                layer_wdata <= wdata[15:0];
            end
        end
    end

    // Active copy loads from pre-write staging, so a same-edge staging write lands next frame
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st_en          <= '1;
            st_key         <= COLOR_WIDTH'(KEY_COLOR_RESET);
            st_bg          <= COLOR_WIDTH'(BG_COLOR_RESET);
            act_en         <= '1;
            act_key        <= COLOR_WIDTH'(KEY_COLOR_RESET);
            act_bg         <= COLOR_WIDTH'(BG_COLOR_RESET);
            commit_pending <= 1'b0;
        end else begin
            if (apply) begin
                act_en  <= st_en;
                act_key <= st_key;
                act_bg  <= st_bg;
            end
            if (ctrl_wr) begin
                case (ctrl_off[1:0])
                    CTRL_LAYER_EN: st_en  <= wdata[LAYER_COUNT-1:0];
                    CTRL_KEY:      st_key <= wdata[COLOR_WIDTH-1:0];
                    CTRL_BG:       st_bg  <= wdata[COLOR_WIDTH-1:0];
                    default:       ;
                endcase
            end
            if (ctrl_wr && (ctrl_off[1:0] == CTRL_COMMIT)) begin
                commit_pending <= 1'b1;
            end else if (apply) begin
                commit_pending <= 1'b0;
            end
        end
    end

    gpu_layer_mux #(
        .LAYER_COUNT (LAYER_COUNT),
        .COLOR_WIDTH (COLOR_WIDTH)
    ) u_mux (
        .layer_pixel (pix_s1),
        .layer_en    (act_en),
        .key_color   (act_key),
        .bg_color    (act_bg),
        .color       (mux_color)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pix_s1    <= '0;
            vis_s1    <= 1'b0;
            color_out <= '0;
        end else if (pixel_en) begin
            pix_s1    <= layer_pixel;
            vis_s1    <= visible;
            color_out <= vis_s1 ? mux_color : '0;
        end
    end

    assign red   = color_out[COLOR_WIDTH-1 -: THIRD];
    assign green = color_out[2*THIRD-1 -: THIRD];
    assign blue  = color_out[THIRD-1:0];

endmodule
`default_nettype wire

// File: tb/tb_gpu_compositor.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_gpu_compositor : scoreboard bench with a behavioural model        |
// | Rev 1.0 : initial release                                            |
// +----------------------------------------------------------------------+
module tb_gpu_compositor;

    localparam int N    = 5;
    localparam int LAS  = 4216;
    localparam int CW   = 12;
    localparam int CTRL = N * LAS;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [23:0]   waddr = '0;
    logic [31:0]   wdata = '0;
    logic          wen = 1'b0;
    logic [15:0]   layer_waddr;
    logic [15:0]   layer_wdata;
    logic [N-1:0]  layer_wen;
    logic          pixel_en = 1'b0;
    logic          frame_start = 1'b0;
    logic          visible = 1'b0;
    logic [N*CW-1:0] layer_pixel = '0;
    logic [3:0]    red, green, blue;
    logic          commit_pending;

    gpu_compositor dut (
        .clk            (clk),
        .rst            (rst),
        .waddr          (waddr),
        .wdata          (wdata),
        .wen            (wen),
        .layer_waddr    (layer_waddr),
        .layer_wdata    (layer_wdata),
        .layer_wen      (layer_wen),
        .pixel_en       (pixel_en),
        .frame_start    (frame_start),
        .visible        (visible),
        .layer_pixel    (layer_pixel),
        .red            (red),
        .green          (green),
        .blue           (blue),
        .commit_pending (commit_pending)
    );

    always #5 clk = ~clk;

    typedef struct { int e; logic [N-1:0] wen; logic [15:0] addr; logic [15:0] data; } wr_t;
    typedef struct { int e; logic [CW-1:0] col; } px_t;
    typedef struct { int e; logic p; } pd_t;

    wr_t wr_q[$];
    px_t px_q[$];
    pd_t pd_q[$];

    int checks = 0;
    int errors = 0;
    int edge_cnt = 0;
    logic [CW-1:0] last_col = '0;

    // Reference state: what software has written and what the display uses
    logic [N-1:0]    m_st_en, m_act_en;
    logic [CW-1:0]   m_st_key, m_act_key, m_st_bg, m_act_bg;
    logic            m_pend;
    logic [N*CW-1:0] m_s1_pix;
    logic            m_s1_vis;

    always @(posedge clk) edge_cnt++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got %h expected %h", name, edge_cnt, act, exp);
        end
    endtask

    function automatic logic [CW-1:0] composite(input logic [N*CW-1:0] pix, input logic [N-1:0] en,
                                                input logic [CW-1:0] key, input logic [CW-1:0] bg);
        for (int i = 0; i < N; i++) begin
            if (en[i] && pix[i*CW +: CW] != key) return pix[i*CW +: CW];
        end
        return bg;
    endfunction

    task automatic model_reset();
        m_st_en = '1; m_act_en = '1;
        m_st_key = 12'hFFF; m_act_key = 12'hFFF;
        m_st_bg = 12'h000; m_act_bg = 12'h000;
        m_pend = 1'b0; m_s1_pix = '0; m_s1_vis = 1'b0;
        wr_q.delete(); px_q.delete(); pd_q.delete();
        last_col = '0;
    endtask

    // Apply one clock's worth of stimulus, record expectations, wait for the edge
    task automatic drive(input logic w, input int word, input logic [31:0] d,
                         input logic pen, input logic fs, input logic vis, input logic [N*CW-1:0] pix);
        int e;
        logic applied, commit_hit;
        e = edge_cnt + 1;
        wen = w; waddr = 24'(word) << 2; waddr[1:0] = 2'($urandom_range(0, 3)); wdata = d;
        pixel_en = pen; frame_start = fs; visible = vis; layer_pixel = pix;
        if (pen) begin
            px_q.push_back('{e, m_s1_vis ? composite(m_s1_pix, m_act_en, m_act_key, m_act_bg) : 12'h000});
            m_s1_pix = pix; m_s1_vis = vis;
        end
        applied = fs && pen && m_pend;
        if (applied) begin
            m_act_en = m_st_en; m_act_key = m_st_key; m_act_bg = m_st_bg;
        end
        commit_hit = 1'b0;
        if (w) begin
            if (word < CTRL) begin
                wr_q.push_back('{e, N'(1) << (word / LAS), 16'(word % LAS), d[15:0]});
            end else if (word == CTRL + 0) m_st_en = d[N-1:0];
            else if (word == CTRL + 1) m_st_key = d[CW-1:0];
            else if (word == CTRL + 2) m_st_bg = d[CW-1:0];
            else if (word == CTRL + 3) commit_hit = 1'b1;
        end
        if (commit_hit) m_pend = 1'b1;
        else if (applied) m_pend = 1'b0;
        pd_q.push_back('{e, m_pend});
        @(posedge clk); #1;
        wen = 1'b0; frame_start = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 0, 32'h0, 1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        model_reset();
        wen = 1'b0; pixel_en = 1'b0; frame_start = 1'b0; visible = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    // Monitor: every cycle compare DUT outputs against whatever is due this edge
    always @(negedge clk) begin
        if (!rst) begin
            chk("reset_wen", 32'(layer_wen), 32'h0);
            chk("reset_rgb", 32'({red, green, blue}), 32'h0);
            chk("reset_pending", 32'(commit_pending), 32'h0);
        end else begin
            if (wr_q.size() > 0 && wr_q[0].e == edge_cnt) begin
                chk("layer_wen", 32'(layer_wen), 32'(wr_q[0].wen));
                chk("layer_waddr", 32'(layer_waddr), 32'(wr_q[0].addr));
                chk("layer_wdata", 32'(layer_wdata), 32'(wr_q[0].data));
                void'(wr_q.pop_front());
            end else begin
                chk("layer_wen_idle", 32'(layer_wen), 32'h0);
            end
            if (px_q.size() > 0 && px_q[0].e == edge_cnt) begin
                last_col = px_q[0].col;
                void'(px_q.pop_front());
            end
            chk("rgb", 32'({red, green, blue}), 32'(last_col));
            if (pd_q.size() > 0 && pd_q[0].e == edge_cnt) begin
                chk("commit_pending", 32'(commit_pending), 32'(pd_q[0].p));
                void'(pd_q.pop_front());
            end
        end
    end

    function automatic logic [CW-1:0] rand_col();
        case ($urandom_range(0, 3))
            0:       return 12'hFFF;
            1:       return m_st_key;
            default: return 12'($urandom);
        endcase
    endfunction

    logic [N*CW-1:0] pix_a;
    logic [N*CW-1:0] pix_r;

    initial begin
        model_reset();
        #2;
        do_reset();

        // Layer 2 write decode
        drive(1'b1, LAS*2 + 5, 32'h0000ABCD, 1'b0, 1'b0, 1'b0, '0);
        idle(2);

        // Default config: layer 0 keyed out, layer 1 shows
        pix_a = {12'h000, 12'h000, 12'h456, 12'h123, 12'hFFF};
        drive(1'b0, 0, 0, 1'b1, 1'b1, 1'b1, pix_a);
        drive(1'b0, 0, 0, 1'b1, 1'b0, 1'b1, pix_a);
        idle(2);

        // Staged writes have no effect until committed at frame start
        drive(1'b1, CTRL + 0, 32'h0, 1'b0, 1'b0, 1'b0, '0);
        drive(1'b1, CTRL + 2, 32'h0F0, 1'b1, 1'b0, 1'b1, pix_a);
        drive(1'b0, 0, 0, 1'b1, 1'b0, 1'b1, pix_a);
        drive(1'b1, CTRL + 3, 32'h5, 1'b1, 1'b0, 1'b1, pix_a);
        drive(1'b0, 0, 0, 1'b1, 1'b1, 1'b1, pix_a);
        drive(1'b0, 0, 0, 1'b1, 1'b0, 1'b1, pix_a);
        drive(1'b0, 0, 0, 1'b1, 1'b0, 1'b1, pix_a);

        // Commit coinciding with frame start defers to the next frame
        drive(1'b1, CTRL + 2, 32'h00F, 1'b1, 1'b0, 1'b1, pix_a);
        drive(1'b1, CTRL + 3, 32'h0, 1'b1, 1'b1, 1'b1, pix_a);
        for (int i = 0; i < 6; i++) drive(1'b0, 0, 0, 1'b1, 1'b0, 1'b1, pix_a);
        drive(1'b1, CTRL + 2, 32'h0AA, 1'b1, 1'b1, 1'b1, pix_a);
        drive(1'b0, 0, 0, 1'b1, 1'b0, 1'b1, pix_a);
        drive(1'b0, 0, 0, 1'b1, 1'b0, 1'b1, pix_a);

        // Beyond the control block: ignored; invisible pixels are black
        drive(1'b1, CTRL + 9, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, pix_a);
        drive(1'b0, 0, 0, 1'b1, 1'b0, 1'b0, pix_a);
        drive(1'b0, 0, 0, 1'b1, 1'b0, 1'b1, pix_a);
        idle(2);

        // Reset while a commit is pending restores defaults
        drive(1'b1, CTRL + 1, 32'h123, 1'b0, 1'b0, 1'b0, '0);
        drive(1'b1, CTRL + 3, 32'h0, 1'b0, 1'b0, 1'b0, '0);
        drive(1'b1, LAS + 7, 32'h1234, 1'b1, 1'b0, 1'b1, pix_a);
        do_reset();
        drive(1'b0, 0, 0, 1'b1, 1'b1, 1'b1, pix_a);
        drive(1'b0, 0, 0, 1'b1, 1'b0, 1'b1, pix_a);
        drive(1'b0, 0, 0, 1'b1, 1'b0, 1'b1, pix_a);

        // Randomised traffic
        for (int i = 0; i < 600; i++) begin
            int word;
            logic w;
            for (int l = 0; l < N; l++) pix_r[l*CW +: CW] = rand_col();
            w = ($urandom_range(0, 2) == 0);
            case ($urandom_range(0, 3))
                0:       word = $urandom_range(0, CTRL - 1);
                1:       word = CTRL + $urandom_range(0, 3);
                2:       word = CTRL + $urandom_range(0, 2);
                default: word = $urandom_range(CTRL + 4, CTRL + 2000);
            endcase
            drive(w, word, $urandom, ($urandom_range(0, 2) != 0), ($urandom_range(0, 15) == 0),
                  ($urandom_range(0, 4) != 0), pix_r);
        end
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
